// File: rtl/cva6_l2tlb_pkg.sv
// ============================================================================
// Module : cva6_l2tlb_pkg
// Brief  : Shared widths, entry/key structs and FSM states for the L2 TLB.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cva6_l2tlb_pkg;

  localparam int unsigned VPN_W      = 27;
  localparam int unsigned ASID_W     = 16;
  localparam int unsigned VMID_W     = 14;
  localparam int unsigned PPN_W      = 44;
  localparam int unsigned PERM_W     = 8;
  localparam int unsigned PERM_G_BIT = 5;

  // Tag fields are VPN-wide; the set-index bits are stored as zero.
  typedef struct packed {
    logic              valid;
    logic [VPN_W-1:0]  tag;
    logic [ASID_W-1:0] asid;
    logic [VMID_W-1:0] vmid;
    logic [PPN_W-1:0]  ppn;
    logic [PERM_W-1:0] perm;
  } l2tlb_entry_t;

  typedef struct packed {
    logic [VPN_W-1:0]  tag;
    logic [ASID_W-1:0] asid;
    logic [VMID_W-1:0] vmid;
  } l2tlb_key_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } l2tlb_state_e;

endpackage

`default_nettype wire

// File: rtl/cva6_l2tlb_victim_sel.sv
// ============================================================================
// Module : cva6_l2tlb_victim_sel
// Brief  : Refill way choice: matching way, else lowest invalid, else RR.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cva6_l2tlb_victim_sel
  import cva6_l2tlb_pkg::*;
#(
  parameter  int unsigned Assoc = 4,
  localparam int unsigned WayW  = (Assoc > 1) ? $clog2(Assoc) : 1
) (
  input  logic [Assoc-1:0] valid_i,
  input  l2tlb_key_t       keys_i [Assoc],
  input  l2tlb_key_t       key_i,
  input  logic [WayW-1:0]  rr_i,
  output logic [WayW-1:0]  victim_o,
  output logic             use_rr_o
);

  logic            match_found;
  logic [WayW-1:0] match_way;
  logic            inv_found;
  logic [WayW-1:0] inv_way;

  always_comb begin
    match_found = 1'b0;
    match_way   = '0;
    inv_found   = 1'b0;
    inv_way     = '0;
    for (int unsigned w = 0; w < Assoc; w++) begin
      if (!match_found && valid_i[WayW'(w)] && (keys_i[WayW'(w)] == key_i)) begin
        match_found = 1'b1;
        match_way   = WayW'(w);
      end
      if (!inv_found && !valid_i[WayW'(w)]) begin
        inv_found = 1'b1;
        inv_way   = WayW'(w);
      end
    end
    use_rr_o = !match_found && !inv_found;
    victim_o = match_found ? match_way : (inv_found ? inv_way : rr_i);
  end

endmodule

`default_nettype wire

// File: rtl/cva6_l2_tlb.sv
// ============================================================================
// Module : cva6_l2_tlb
// Brief  : Set-associative shared L2 TLB, 1-cycle pipelined lookup, PTW refill,
//          sequential set-by-set flush. CVA6_L2TLB_PERF_EN adds hit/miss counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cva6_l2_tlb
  import cva6_l2tlb_pkg::*;
#(
  parameter int unsigned NrEntries = 128,
  parameter int unsigned Assoc     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              lu_req_i,
  input  logic [VPN_W-1:0]  lu_vpn_i,
  input  logic [ASID_W-1:0] lu_asid_i,
  input  logic [VMID_W-1:0] lu_vmid_i,
  output logic              lu_ready_o,
  output logic              lu_valid_o,
  output logic              lu_hit_o,
  output logic [PPN_W-1:0]  lu_ppn_o,
  output logic [PERM_W-1:0] lu_perm_o,
  input  logic              refill_valid_i,
  input  logic [VPN_W-1:0]  refill_vpn_i,
  input  logic [ASID_W-1:0] refill_asid_i,
  input  logic [VMID_W-1:0] refill_vmid_i,
  input  logic [PPN_W-1:0]  refill_ppn_i,
  input  logic [PERM_W-1:0] refill_perm_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned SETS  = NrEntries / Assoc;
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = VPN_W - IDX_W;
  localparam int unsigned WAY_W = (Assoc > 1) ? $clog2(Assoc) : 1;

  l2tlb_state_e     state_q, state_d;
  logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [Assoc-1:0]  valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][Assoc];
  logic [ASID_W-1:0] asid_q  [SETS][Assoc];
  logic [VMID_W-1:0] vmid_q  [SETS][Assoc];
  logic [PPN_W-1:0]  ppn_q   [SETS][Assoc];
  logic [PERM_W-1:0] perm_q  [SETS][Assoc];

  logic              lu_valid_q, lu_hit_q;
  logic [PPN_W-1:0]  lu_ppn_q;
  logic [PERM_W-1:0] lu_perm_q;

  logic [IDX_W-1:0]  lu_idx, rf_idx;
  logic [TAG_W-1:0]  lu_tag, rf_tag;
  logic              lu_accept, rf_we;
  logic              lu_hit;
  logic [PPN_W-1:0]  lu_ppn;
  logic [PERM_W-1:0] lu_perm;
  l2tlb_entry_t      lu_set  [Assoc];
  l2tlb_key_t        rf_keys [Assoc];
  l2tlb_key_t        rf_key;
  logic [WAY_W-1:0]  victim;
  logic              victim_from_rr;
  logic [WAY_W-1:0]  rr_next;

  assign lu_idx = lu_vpn_i[IDX_W-1:0];
  assign lu_tag = lu_vpn_i[VPN_W-1:IDX_W];
  assign rf_idx = refill_vpn_i[IDX_W-1:0];
  assign rf_tag = refill_vpn_i[VPN_W-1:IDX_W];

  assign lu_ready_o = (state_q == IDLE) && !flush_i && !refill_valid_i;
  assign lu_accept  = lu_req_i && lu_ready_o;
  assign rf_we      = refill_valid_i && (state_q == IDLE);

  always_comb begin
    for (int unsigned w = 0; w < Assoc; w++) begin
      lu_set[w].valid  = valid_q[lu_idx][WAY_W'(w)];
      lu_set[w].tag    = VPN_W'(tag_q[lu_idx][WAY_W'(w)]);
      lu_set[w].asid   = asid_q[lu_idx][WAY_W'(w)];
      lu_set[w].vmid   = vmid_q[lu_idx][WAY_W'(w)];
      lu_set[w].ppn    = ppn_q[lu_idx][WAY_W'(w)];
      lu_set[w].perm   = perm_q[lu_idx][WAY_W'(w)];
      rf_keys[w].tag   = VPN_W'(tag_q[rf_idx][WAY_W'(w)]);
      rf_keys[w].asid  = asid_q[rf_idx][WAY_W'(w)];
      rf_keys[w].vmid  = vmid_q[rf_idx][WAY_W'(w)];
    end
  end

  assign rf_key.tag  = VPN_W'(rf_tag);
  assign rf_key.asid = refill_asid_i;
  assign rf_key.vmid = refill_vmid_i;

  // Global (G) entries match any ASID; the lowest hitting way wins.
  always_comb begin
    lu_hit  = 1'b0;
    lu_ppn  = '0;
    lu_perm = '0;
    for (int unsigned w = 0; w < Assoc; w++) begin
      if (!lu_hit && lu_set[w].valid && (lu_set[w].tag == VPN_W'(lu_tag)) &&
          (lu_set[w].vmid == lu_vmid_i) &&
          ((lu_set[w].asid == lu_asid_i) || lu_set[w].perm[PERM_G_BIT])) begin
        lu_hit  = 1'b1;
        lu_ppn  = lu_set[w].ppn;
        lu_perm = lu_set[w].perm;
      end
    end
  end

  cva6_l2tlb_victim_sel #(
    .Assoc (Assoc)
  ) u_victim_sel (
    .valid_i  (valid_q[rf_idx]),
    .keys_i   (rf_keys),
    .key_i    (rf_key),
    .rr_i     (rr_q[rf_idx]),
    .victim_o (victim),
    .use_rr_o (victim_from_rr)
  );

  assign rr_next = (rr_q[rf_idx] == WAY_W'(Assoc - 1)) ? '0 : rr_q[rf_idx] + WAY_W'(1);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_i) begin
          flush_cnt_d = '0;
        end else if (flush_cnt_q == IDX_W'(SETS - 1)) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (state_q == FLUSH) begin
        valid_q[flush_cnt_q] <= '0;
      end
      if (rf_we) begin
        valid_q[rf_idx][victim] <= 1'b1;
        if (victim_from_rr) begin
          rr_q[rf_idx] <= rr_next;
        end
      end
    end
  end

  // Payload arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (rf_we) begin
      tag_q[rf_idx][victim]  <= rf_tag;
      asid_q[rf_idx][victim] <= refill_asid_i;
      vmid_q[rf_idx][victim] <= refill_vmid_i;
      ppn_q[rf_idx][victim]  <= refill_ppn_i;
      perm_q[rf_idx][victim] <= refill_perm_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lu_valid_q <= 1'b0;
      lu_hit_q   <= 1'b0;
      lu_ppn_q   <= '0;
      lu_perm_q  <= '0;
    end else begin
      lu_valid_q <= lu_accept;
      lu_hit_q   <= lu_accept && lu_hit;
      lu_ppn_q   <= lu_accept ? lu_ppn  : '0;
      lu_perm_q  <= lu_accept ? lu_perm : '0;
    end
  end

  assign lu_valid_o = lu_valid_q;
  assign lu_hit_o   = lu_hit_q;
  assign lu_ppn_o   = lu_ppn_q;
  assign lu_perm_o  = lu_perm_q;

`ifdef CVA6_L2TLB_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lu_valid_q) begin
      if (lu_hit_q) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/cva6_l2_tlb.md
CVA6_L2_TLB -- requirements
Module: cva6_l2_tlb

Interface
REQ-001 SHALL have parameter NrEntries, default 128, total 4K-page entries.
REQ-002 SHALL have parameter Assoc, default 4, ways per set; sets = NrEntries/Assoc (32 by default), a power of two.
REQ-003 SHALL have the following ports, clock and reset first:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  invalidate all entries
lu_req_i  in  1  lookup request (an L1 TLB miss)
lu_vpn_i  in  27  lookup VPN
lu_asid_i  in  16  lookup ASID
lu_vmid_i  in  14  lookup VMID
lu_ready_o  out  1  lookup can be accepted
lu_valid_o  out  1  lookup result valid, one-cycle pulse
lu_hit_o  out  1  lookup hit
lu_ppn_o  out  44  hit PPN
lu_perm_o  out  8  hit PTE flags D,A,G,U,X,W,R,V
refill_valid_i  in  1  PTW refill write
refill_vpn_i  in  27  refill VPN
refill_asid_i  in  16  refill ASID
refill_vmid_i  in  14  refill VMID
refill_ppn_i  in  44  refill PPN
refill_perm_i  in  8  refill PTE flags; bit 5 is G
hit_cnt_o  out  32  hit counter (CVA6_L2TLB_PERF_EN only)
miss_cnt_o  out  32  miss counter (CVA6_L2TLB_PERF_EN only)

Function
REQ-004 SHALL index a set with vpn[log2(sets)-1:0] and use the remaining upper VPN bits as the tag.
REQ-005 SHALL drive lu_ready_o = (state==IDLE) && !flush_i && !refill_valid_i.
REQ-006 SHALL accept a lookup when lu_req_i && lu_ready_o.
REQ-007 SHALL compare against the array contents in the accept cycle and register the result.
REQ-008 SHALL assert lu_valid_o exactly one cycle after accept, with hit/ppn/perm; latency is 1 and lookups are fully pipelined at 1 per cycle.
REQ-009 SHALL define a way hit as valid && tag equal && vmid equal && (asid equal || G).
REQ-010 SHALL select the lowest-numbered way when several ways hit.
REQ-011 SHALL drive lu_ppn_o and lu_perm_o to 0 when lu_hit_o=0.
REQ-012 SHALL write a refill in IDLE the cycle refill_valid_i is high; a refill has priority over a lookup.
REQ-013 SHALL choose the refill victim way as: a way matching tag/asid/vmid (overwrite); else the lowest invalid way; else the per-set round-robin pointer.
REQ-014 SHALL increment the round-robin pointer mod Assoc only when it supplied the victim.
REQ-015 SHALL drop refills while in FLUSH.
REQ-016 SHALL implement FSM IDLE->FLUSH on flush_i. FLUSH clears all way valids of set flush_cnt per cycle, counting 0..sets-1, then returns to IDLE; this takes sets cycles (32 by default).
REQ-017 SHALL restart flush_cnt at 0 when flush_i is asserted during FLUSH.
REQ-018 SHALL still deliver the result of a lookup accepted the cycle before flush_i, computed from pre-flush contents.

Reset
REQ-019 SHALL on rst_i asynchronously clear: all valid bits, RR pointers, flush_cnt, state (to IDLE), lu_valid_o, lu_hit_o, lu_ppn_o, lu_perm_o, and the counters.
REQ-020 SHALL NOT reset the tag/ppn/perm arrays.
REQ-021 SHALL abandon a reset asserted mid-flush or mid-lookup, with no result pulse after release.

Configuration
REQ-022 SHALL with CVA6_L2TLB_PERF_EN defined provide hit_cnt_o/miss_cnt_o: 32-bit saturating counters, each incremented when lu_valid_o is asserted with lu_hit_o=1 / =0 respectively.
REQ-023 SHALL without CVA6_L2TLB_PERF_EN drive both counter outputs to constant 0 and contain no counter flops.

Structure
REQ-024 SHALL place in shared package cva6_l2tlb_pkg: the entry struct typedef (valid, tag, asid, vmid, ppn, perm), the VPN/ASID/VMID/PPN width constants, and the FSM state enum.
REQ-025 SHALL implement victim selection (REQ-013/014) in sub-module cva6_l2tlb_victim_sel.

Verification
REQ-026 SHALL cover: refill vpn=0x0000123, asid=5, vmid=1, ppn=0x80000, perm=0xCF; then lookup with the same values -> next cycle lu_valid_o=1, lu_hit_o=1, lu_ppn_o=0x80000, lu_perm_o=0xCF.
REQ-027 SHALL cover: the same entry looked up with asid=6 -> miss; a refill with perm G bit set (0xEF), then asid=6 -> hit.
REQ-028 SHALL cover: 5 refills into set 3 (vpn 0x03,0x23,0x43,0x63,0x83) -> the 5th replaces way 0 and a lookup of 0x03 misses.
REQ-029 SHALL cover: flush_i pulse -> lu_ready_o low for 32 cycles, a refill during flush is dropped, and all prior entries miss afterwards.
REQ-030 SHALL cover: flush_i re-asserted at flush cycle 10 -> flush completes 32 cycles after the re-assertion.
REQ-031 SHALL cover: refill_valid_i and lu_req_i in the same cycle -> refill written and lu_ready_o=0; with PERF_EN, 3 hits and 2 misses -> hit_cnt_o=3, miss_cnt_o=2.
